// File: rtl/pcfx_cd_pkg.sv
// Shared constants and types for the PC-FX CD command path.
// SCSI status/opcode values and the router state encoding.
package pcfx_cd_pkg;

    localparam logic [7:0] ST_GOOD            = 8'h00;
    localparam logic [7:0] ST_CHECK           = 8'h02;
    localparam logic [7:0] OP_TEST_UNIT_READY = 8'h00;
    localparam logic [7:0] OP_REQUEST_SENSE   = 8'h03;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_DISPATCH,
        RS_ACTIVE
    } router_st_t;

endpackage

// File: rtl/cd_watchdog.sv
// Idle-cycle watchdog: counts while enabled, fires once at TIMEOUT_CYC-1.
// Counter parks one past the terminal value so it never wraps or re-fires.
module cd_watchdog #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd2_000_000
) (
    input  logic CLK,
    input  logic RES,
    input  logic CLR,
    input  logic EN,
    output logic EXPIRE
);

    localparam int TW = $clog2(int'(TIMEOUT_CYC) + 1);
    localparam logic [TW-1:0] LIM = TW'(TIMEOUT_CYC - 24'd1);
    localparam logic [TW-1:0] TOP = TW'(TIMEOUT_CYC);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_cnt <= '0;
        end else if (CLR) begin
            r_cnt <= '0;
        end else if (EN && (r_cnt != TOP)) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign EXPIRE = EN && (r_cnt == LIM);

endmodule

// File: rtl/cd_cmd_router.sv
// Routes bridge commands to the HPS disc model or the empty-drive responder,
// forwards the selected responder's data/status and aborts hung commands.
module cd_cmd_router
    import pcfx_cd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYC = 24'd2_000_000
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CD_PRESENT,
    input  logic [95:0] COMMAND,
    input  logic        COMM_SEND,
    output logic        STAT_GET,
    output logic [7:0]  STATUS,
    output logic [7:0]  CD_DATA,
    output logic        CD_WR,
    output logic        BUSY,
    output logic        OVERRUN,
    output logic        TIMEOUT,
    output logic [95:0] TGT_COMMAND,
    output logic        HPS_COMM_SEND,
    input  logic        HPS_STAT_GET,
    input  logic [7:0]  HPS_STATUS,
    input  logic [7:0]  HPS_DATA,
    input  logic        HPS_WR,
    output logic        FK_COMM_SEND,
    input  logic        FK_STAT_GET,
    input  logic [7:0]  FK_STATUS,
    input  logic [7:0]  FK_DATA,
    input  logic        FK_WR
);

    router_st_t r_state;
    router_st_t w_next;

    logic        r_sel;
    logic        r_wr_prev;
    logic        r_stat_get;
    logic [7:0]  r_status;
    logic [7:0]  r_cd_data;
    logic        r_cd_wr;
    logic        r_busy;
    logic        r_overrun;
    logic        r_timeout;
    logic [95:0] r_cmd;
    logic        r_hps_send;
    logic        r_fk_send;

    logic        w_tgt_stat;
    logic [7:0]  w_tgt_status;
    logic [7:0]  w_tgt_data;
    logic        w_tgt_wr;
    logic        w_active;
    logic        w_accept;
    logic        w_expire;
    logic        w_wd_clr;
    logic        w_wd_en;

    assign w_tgt_stat   = r_sel ? HPS_STAT_GET : FK_STAT_GET;
    assign w_tgt_status = r_sel ? HPS_STATUS   : FK_STATUS;
    assign w_tgt_data   = r_sel ? HPS_DATA     : FK_DATA;
    assign w_tgt_wr     = r_sel ? HPS_WR       : FK_WR;

    assign w_active = (r_state == RS_ACTIVE);
    // The status cycle still counts as busy for new commands.
    assign w_accept = COMM_SEND && (r_state == RS_IDLE) && !r_stat_get;

    assign w_wd_clr = (r_state == RS_IDLE) || (w_active && (w_tgt_wr != r_wr_prev));
    assign w_wd_en  = (r_state != RS_IDLE);

    cd_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .CLK    (CLK),
        .RES    (RES),
        .CLR    (w_wd_clr),
        .EN     (w_wd_en),
        .EXPIRE (w_expire)
    );

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= RS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RS_IDLE:     if (w_accept) w_next = RS_DISPATCH;
            RS_DISPATCH: w_next = RS_ACTIVE;
            RS_ACTIVE:   if (w_tgt_stat || w_expire) w_next = RS_IDLE;
            default:     w_next = RS_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_sel      <= 1'b0;
            r_wr_prev  <= 1'b0;
            r_stat_get <= 1'b0;
            r_status   <= 8'h00;
            r_cd_data  <= 8'h00;
            r_cd_wr    <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
            r_cmd      <= '0;
            r_hps_send <= 1'b0;
            r_fk_send  <= 1'b0;
        end else begin
            r_stat_get <= 1'b0;
            r_timeout  <= 1'b0;
            r_hps_send <= 1'b0;
            r_fk_send  <= 1'b0;
            r_overrun  <= COMM_SEND && !w_accept;
            r_wr_prev  <= w_tgt_wr;
            if (w_accept) begin
                r_cmd      <= COMMAND;
                r_sel      <= CD_PRESENT;
                r_busy     <= 1'b1;
                r_hps_send <= CD_PRESENT;
                r_fk_send  <= !CD_PRESENT;
            end
            if (w_active) begin
                r_cd_data <= w_tgt_data;
                r_cd_wr   <= w_tgt_wr;
                if (w_tgt_stat) begin
                    r_status   <= w_tgt_status;
                    r_stat_get <= 1'b1;
                    r_cd_wr    <= 1'b0;
                    r_busy     <= 1'b0;
                end else if (w_expire) begin
                    r_status   <= ST_CHECK;
                    r_stat_get <= 1'b1;
                    r_timeout  <= 1'b1;
                    r_cd_wr    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            end
        end
    end

    assign STAT_GET      = r_stat_get;
    assign STATUS        = r_status;
    assign CD_DATA       = r_cd_data;
    assign CD_WR         = r_cd_wr;
    assign BUSY          = r_busy;
    assign OVERRUN       = r_overrun;
    assign TIMEOUT       = r_timeout;
    assign TGT_COMMAND   = r_cmd;
    assign HPS_COMM_SEND = r_hps_send;
    assign FK_COMM_SEND  = r_fk_send;

endmodule
